// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the 7-segment display scanner: segment patterns
// (active-high, {g,f,e,d,c,b,a}) and pin polarities of the display bank.
package bcd_display_scan_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Common-anode bank: segments, decimal point and anodes are all active-low.
    localparam logic AN_ON  = 1'b0;
    localparam logic AN_OFF = 1'b1;
    localparam logic DP_ON  = 1'b0;
    localparam logic DP_OFF = 1'b1;

    function automatic logic [6:0] seg_drive(input logic [6:0] pattern);
        return ~pattern;
    endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// Digit-word input bundle and display-pin output bundle of the scanner.
// The driver side (master) owns the i_* signals; the scanner (slave) owns the o_* pins.
interface bcd_display_scan_if #(parameter int NDIG = 4);

    logic                i_en;
    logic [4*NDIG-1:0]   i_digits;
    logic                i_blank_lz;
    logic [NDIG-1:0]     i_dp_in;
    logic [6:0]          o_seg_n;
    logic                o_dp_n;
    logic [NDIG-1:0]     o_an_n;
    logic                o_frame_done;

    modport master (
        output i_en, i_digits, i_blank_lz, i_dp_in,
        input  o_seg_n, o_dp_n, o_an_n, o_frame_done
    );

    modport slave (
        input  i_en, i_digits, i_blank_lz, i_dp_in,
        output o_seg_n, o_dp_n, o_an_n, o_frame_done
    );

endinterface

// File: rtl/bcd_display_scan_bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder; codes 10..15 show a dash.
module bcd_to_7seg
    import bcd_display_scan_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_val)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode 7-segment scanner with per-frame snapshot,
// leading-zero blanking and an all-anodes-off dead time at each slot start.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int DIV  = 1000,
    parameter int DEAD = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    bcd_display_scan_if.slave bus
);

    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);

    logic [PW-1:0]      r_pre, w_pre_nxt;
    logic [IW-1:0]      r_idx, w_idx_nxt;
    logic [4*NDIG-1:0]  r_snap_dig, w_snap_dig;
    logic [NDIG-1:0]    r_snap_dp, w_snap_dp;
    logic               r_snap_blk, w_snap_blk;
    logic               r_primed;
    logic               w_tick, w_wrap, w_load;
    logic [NDIG-1:0]    w_zero_above;
    logic [3:0]         w_cur_val;
    logic [6:0]         w_cur_pat;
    logic               w_cur_blank;
    logic [NDIG-1:0]    w_an_nxt;

    logic [6:0]         r_seg_n;
    logic               r_dp_n;
    logic [NDIG-1:0]    r_an_n;
    logic               r_frame_done;

    always_comb begin
        logic acc;
        w_tick = bus.i_en && (r_pre == PW'(DIV - 1));
        w_wrap = w_tick && (r_idx == IW'(NDIG - 1));
        // Snapshot at each frame boundary, plus once on the first enabled cycle after reset.
        w_load = bus.i_en && (w_wrap || !r_primed);

        w_pre_nxt = r_pre;
        w_idx_nxt = r_idx;
        if (w_tick) begin
            w_pre_nxt = '0;
            w_idx_nxt = w_wrap ? '0 : r_idx + IW'(1);
        end else if (bus.i_en) begin
            w_pre_nxt = r_pre + PW'(1);
        end

        w_snap_dig = w_load ? bus.i_digits   : r_snap_dig;
        w_snap_dp  = w_load ? bus.i_dp_in    : r_snap_dp;
        w_snap_blk = w_load ? bus.i_blank_lz : r_snap_blk;

        // w_zero_above[k]: digit k and every digit above it are zero.
        acc = 1'b1;
        w_zero_above = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            acc = acc && (w_snap_dig[4*k +: 4] == 4'd0);
            w_zero_above[k] = acc;
        end

        w_cur_val   = w_snap_dig[{w_idx_nxt, 2'b00} +: 4];
        w_cur_blank = w_snap_blk && (w_idx_nxt != '0) && w_zero_above[w_idx_nxt];

        w_an_nxt = {NDIG{AN_OFF}};
        if (bus.i_en && (w_pre_nxt >= PW'(DEAD))) begin
            w_an_nxt[w_idx_nxt] = AN_ON;
        end
    end

    bcd_to_7seg u_dec (
        .i_val (w_cur_val),
        .o_seg (w_cur_pat)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre        <= '0;
            r_idx        <= '0;
            r_snap_dig   <= '0;
            r_snap_dp    <= '0;
            r_snap_blk   <= 1'b0;
            r_primed     <= 1'b0;
            r_seg_n      <= seg_drive(SEG_OFF);
            r_dp_n       <= DP_OFF;
            r_an_n       <= {NDIG{AN_OFF}};
            r_frame_done <= 1'b0;
        end else begin
            r_pre        <= w_pre_nxt;
            r_idx        <= w_idx_nxt;
            r_snap_dig   <= w_snap_dig;
            r_snap_dp    <= w_snap_dp;
            r_snap_blk   <= w_snap_blk;
            if (w_load) begin
                r_primed <= 1'b1;
            end
            // Segments only move while the anodes are dark (slot start or first load).
            if (w_load || w_tick) begin
                r_seg_n <= w_cur_blank ? seg_drive(SEG_OFF) : seg_drive(w_cur_pat);
                r_dp_n  <= w_snap_dp[w_idx_nxt] ? DP_ON : DP_OFF;
            end
            r_an_n       <= w_an_nxt;
            r_frame_done <= w_wrap;
        end
    end

    assign bus.o_seg_n      = r_seg_n;
    assign bus.o_dp_n       = r_dp_n;
    assign bus.o_an_n       = r_an_n;
    assign bus.o_frame_done = r_frame_done;

endmodule
